// File: rtl/zion_rf_pkg.sv
// Shared types for the scoreboarded register file: index/word types, the
// write/forward channel record and width helpers.
package zion_rf_pkg;

  // Channel fields are sized for the widest supported configuration; narrower
  // instances zero-extend into them.
  localparam int unsigned RF_MAX_AW = 8;
  localparam int unsigned RF_MAX_DW = 64;

  typedef logic [RF_MAX_AW-1:0] rf_idx_t;
  typedef logic [RF_MAX_DW-1:0] rf_word_t;

  typedef struct packed {
    logic     vld;
    rf_idx_t  rd;
    rf_word_t dat;
  } rf_chan_t;

  function automatic int unsigned rf_aw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Port-vector width for a count that may legally be zero.
  function automatic int unsigned rf_nz(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/zion_rf_operand_mux.sv
// One read port's operand select: zero register, forward, same-cycle write
// bypass, then array; ready when any live source covers a busy register.
module zion_rf_operand_mux
  import zion_rf_pkg::*;
#(
  parameter int unsigned WR_N  = 2,
  parameter int unsigned FWD_N = 1
) (
  input  rf_idx_t  rs,
  input  rf_word_t arr_dat,
  input  logic     busy,
  input  rf_chan_t fwd [rf_nz(FWD_N)],
  input  rf_chan_t wr  [WR_N],
  output rf_word_t dat,
  output logic     rdy
);

  logic     fwd_hit;
  logic     wr_hit;
  rf_word_t fwd_dat;
  rf_word_t wr_dat;

  always_comb begin
    fwd_hit = 1'b0;
    fwd_dat = '0;
    // Lowest forward index is the youngest stage, so the first hit sticks.
    for (int unsigned j = 0; j < FWD_N; j++) begin
      if (!fwd_hit && fwd[j].vld && (fwd[j].rd == rs)) begin
        fwd_hit = 1'b1;
        fwd_dat = fwd[j].dat;
      end
    end
    wr_hit = 1'b0;
    wr_dat = '0;
    for (int unsigned k = 0; k < WR_N; k++) begin
      if (wr[k].vld && (wr[k].rd == rs)) begin
        wr_hit = 1'b1;
        wr_dat = wr[k].dat;
      end
    end
  end

  always_comb begin
    dat = arr_dat;
    rdy = 1'b1;
    if (rs == '0) begin
      dat = '0;
    end else begin
      if (fwd_hit)     dat = fwd_dat;
      else if (wr_hit) dat = wr_dat;
      rdy = !busy || fwd_hit || wr_hit;
    end
  end

endmodule

// File: rtl/zion_rf_scoreboard_reg_file.sv
// Multi-write-port integer register file with busy-bit scoreboard and
// per-read-port forwarding / write bypass.
module zion_rf_scoreboard_reg_file
  import zion_rf_pkg::*;
#(
  parameter int unsigned REG_NUM      = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RD_PORT_NUM  = 2,
  parameter int unsigned WR_PORT_NUM  = 2,
  parameter int unsigned FWD_PORT_NUM = 1,
  parameter int unsigned AW           = rf_aw(REG_NUM)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [RD_PORT_NUM*AW-1:0]              iRdRs,
  output logic [RD_PORT_NUM*DATA_W-1:0]          oRdDat,
  output logic [RD_PORT_NUM-1:0]                 oRdRdy,
  input  logic [WR_PORT_NUM-1:0]                 iWrEn,
  input  logic [WR_PORT_NUM*AW-1:0]              iWrRd,
  input  logic [WR_PORT_NUM*DATA_W-1:0]          iWrDat,
  input  logic [rf_nz(FWD_PORT_NUM)-1:0]         iFwdVld,
  input  logic [rf_nz(FWD_PORT_NUM)*AW-1:0]      iFwdRd,
  input  logic [rf_nz(FWD_PORT_NUM)*DATA_W-1:0]  iFwdDat,
  input  logic                                   iAllocEn,
  input  logic [AW-1:0]                          iAllocRd,
  output logic [REG_NUM-1:0]                     oBusy
);

  localparam int unsigned FWD_N = rf_nz(FWD_PORT_NUM);

  // Entry 0 is hardwired to zero, so only 1..REG_NUM-1 hold state.
  logic [DATA_W-1:0]  mem_q [1:REG_NUM-1];
  logic [DATA_W-1:0]  mem_d [1:REG_NUM-1];
  logic [REG_NUM-1:1] busy_q;
  logic [REG_NUM-1:1] busy_d;

  rf_chan_t wr_ch  [WR_PORT_NUM];
  rf_chan_t fwd_ch [FWD_N];

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int unsigned k = 0; k < WR_PORT_NUM; k++) begin
      if (iWrEn[k] && (iWrRd[k*AW +: AW] != '0)) begin
        mem_d[iWrRd[k*AW +: AW]]  = iWrDat[k*DATA_W +: DATA_W];
        busy_d[iWrRd[k*AW +: AW]] = 1'b0;
      end
    end
    // Applied after the write clears: the newly issued producer is younger.
    if (iAllocEn && (iAllocRd != '0)) busy_d[iAllocRd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 1; r < REG_NUM; r++) mem_q[r] <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign oBusy = {busy_q, 1'b0};

  always_comb begin
    for (int unsigned k = 0; k < WR_PORT_NUM; k++) begin
      wr_ch[k].vld = iWrEn[k];
      wr_ch[k].rd  = rf_idx_t'(iWrRd[k*AW +: AW]);
      wr_ch[k].dat = rf_word_t'(iWrDat[k*DATA_W +: DATA_W]);
    end
    for (int unsigned j = 0; j < FWD_N; j++) begin
      fwd_ch[j].vld = (FWD_PORT_NUM != 0) && iFwdVld[j];
      fwd_ch[j].rd  = rf_idx_t'(iFwdRd[j*AW +: AW]);
      fwd_ch[j].dat = rf_word_t'(iFwdDat[j*DATA_W +: DATA_W]);
    end
  end

  for (genvar i = 0; i < RD_PORT_NUM; i++) begin : g_rd
    logic [AW-1:0] rs;
    rf_word_t      arr_dat;
    rf_word_t      dat_full;
    logic          busy_rs;
    logic          rdy;
    logic          unused_dat;

    assign rs      = iRdRs[i*AW +: AW];
    assign arr_dat = (rs == '0) ? '0 : rf_word_t'(mem_q[rs]);
    assign busy_rs = (rs != '0) && busy_q[rs];

    zion_rf_operand_mux #(
      .WR_N  (WR_PORT_NUM),
      .FWD_N (FWD_PORT_NUM)
    ) u_mux (
      .rs      (rf_idx_t'(rs)),
      .arr_dat (arr_dat),
      .busy    (busy_rs),
      .fwd     (fwd_ch),
      .wr      (wr_ch),
      .dat     (dat_full),
      .rdy     (rdy)
    );

    assign oRdDat[i*DATA_W +: DATA_W] = dat_full[DATA_W-1:0];
    assign oRdRdy[i]                  = rdy;
    assign unused_dat                 = ^dat_full;
  end

endmodule

// File: tb/tb_zion_rf_scoreboard_reg_file.sv
// Bench for zion_rf_scoreboard_reg_file: directed scenarios plus randomized
// traffic against an array-based reference model.
module tb_zion_rf_scoreboard_reg_file;

  localparam int NR = 32;
  localparam int DW = 32;
  localparam int AWT = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AWT-1:0] rs_a [2];
  logic           wen  [2];
  logic [AWT-1:0] wrd  [2];
  logic [DW-1:0]  wdat [2];
  logic           fvld;
  logic [AWT-1:0] frd;
  logic [DW-1:0]  fdat;
  logic           aen;
  logic [AWT-1:0] ard;

  logic [2*DW-1:0] oRdDat;
  logic [1:0]      oRdRdy;
  logic [NR-1:0]   oBusy;

  zion_rf_scoreboard_reg_file #(
    .REG_NUM      (NR),
    .DATA_W       (DW),
    .RD_PORT_NUM  (2),
    .WR_PORT_NUM  (2),
    .FWD_PORT_NUM (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .iRdRs    ({rs_a[1], rs_a[0]}),
    .oRdDat   (oRdDat),
    .oRdRdy   (oRdRdy),
    .iWrEn    ({wen[1], wen[0]}),
    .iWrRd    ({wrd[1], wrd[0]}),
    .iWrDat   ({wdat[1], wdat[0]}),
    .iFwdVld  (fvld),
    .iFwdRd   (frd),
    .iFwdDat  (fdat),
    .iAllocEn (aen),
    .iAllocRd (ard),
    .oBusy    (oBusy)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_mem  [NR];
  logic          m_busy [NR];

  function automatic logic [NR-1:0] m_busy_vec();
    logic [NR-1:0] v;
    for (int r = 0; r < NR; r++) v[r] = (r != 0) && m_busy[r];
    return v;
  endfunction

  // Reference read: zero reg, forward, newest write (port 1 over 0), array.
  function automatic void m_read(input int rs, output logic [DW-1:0] d, output logic rdy);
    logic hit;
    hit = 1'b0;
    d   = m_mem[rs];
    if (rs == 0) begin
      d = '0;
      hit = 1'b1;
    end else if (fvld && frd == rs) begin
      d = fdat;
      hit = 1'b1;
    end else if (wen[1] && wrd[1] == rs) begin
      d = wdat[1];
      hit = 1'b1;
    end else if (wen[0] && wrd[0] == rs) begin
      d = wdat[0];
      hit = 1'b1;
    end
    rdy = hit || !m_busy[rs];
  endfunction

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      wen[k] = 1'b0; wrd[k] = '0; wdat[k] = '0;
    end
    fvld = 1'b0; frd = '0; fdat = '0;
    aen = 1'b0; ard = '0;
  endtask

  // Commit the model for the edge about to happen, then step past it.
  task automatic tick();
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        m_mem[r] = '0; m_busy[r] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++)
        if (wen[k] && wrd[k] != 0) begin
          m_mem[wrd[k]] = wdat[k];
          m_busy[wrd[k]] = 1'b0;
        end
      if (aen && ard != 0) m_busy[ard] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    rs_a[0] = '0; rs_a[1] = '0;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (oBusy !== '0) begin
      bad++; $display("FAIL reset_busy got=%h exp=0", oBusy);
    end
    for (int r = 0; r < NR; r++) begin
      rs_a[0] = AWT'(r); rs_a[1] = AWT'(NR - 1 - r);
      #1;
      total++;
      if (oRdDat !== '0 || oRdRdy !== 2'b11) begin
        bad++; $display("FAIL reset_read r=%0d got=%h rdy=%b exp=0 rdy=11", r, oRdDat, oRdRdy);
      end
    end
  endtask

  task automatic test_alloc_write();
    idle();
    aen = 1'b1; ard = 5'd5;
    tick();
    aen = 1'b0;
    rs_a[0] = 5'd5;
    #1;
    total++;
    if (oBusy[5] !== 1'b1 || oRdRdy[0] !== 1'b0) begin
      bad++; $display("FAIL alloc_busy busy=%b rdy=%b exp busy=1 rdy=0", oBusy[5], oRdRdy[0]);
    end
    tick();
    tick();
    wen[0] = 1'b1; wrd[0] = 5'd5; wdat[0] = 32'hDEADBEEF;
    #1;
    total++;
    if (oRdDat[31:0] !== 32'hDEADBEEF || oRdRdy[0] !== 1'b1) begin
      bad++; $display("FAIL bypass got=%h rdy=%b exp=deadbeef rdy=1", oRdDat[31:0], oRdRdy[0]);
    end
    tick();
    idle();
    #1;
    total++;
    if (oBusy[5] !== 1'b0 || oRdDat[31:0] !== 32'hDEADBEEF || oRdRdy[0] !== 1'b1) begin
      bad++; $display("FAIL write_commit busy=%b got=%h exp busy=0 dat=deadbeef", oBusy[5], oRdDat[31:0]);
    end
  endtask

  task automatic test_multi_write();
    idle();
    wen[0] = 1'b1; wrd[0] = 5'd7; wdat[0] = 32'h11;
    wen[1] = 1'b1; wrd[1] = 5'd7; wdat[1] = 32'h22;
    rs_a[0] = 5'd7;
    #1;
    total++;
    if (oRdDat[31:0] !== 32'h22) begin
      bad++; $display("FAIL multi_bypass got=%h exp=22", oRdDat[31:0]);
    end
    tick();
    idle();
    #1;
    total++;
    if (oRdDat[31:0] !== 32'h22) begin
      bad++; $display("FAIL multi_array got=%h exp=22", oRdDat[31:0]);
    end
  endtask

  task automatic test_alloc_write_same();
    idle();
    aen = 1'b1; ard = 5'd9;
    tick();
    wen[0] = 1'b1; wrd[0] = 5'd9; wdat[0] = 32'h55;
    tick();
    idle();
    rs_a[1] = 5'd9;
    #1;
    total++;
    if (oBusy[9] !== 1'b1 || oRdRdy[1] !== 1'b0 || oRdDat[63:32] !== 32'h55) begin
      bad++; $display("FAIL alloc_over_write busy=%b rdy=%b dat=%h exp busy=1 rdy=0 dat=55",
                      oBusy[9], oRdRdy[1], oRdDat[63:32]);
    end
  endtask

  task automatic test_fwd_priority();
    idle();
    aen = 1'b1; ard = 5'd3;
    tick();
    idle();
    fvld = 1'b1; frd = 5'd3; fdat = 32'hAA;
    wen[1] = 1'b1; wrd[1] = 5'd3; wdat[1] = 32'hBB;
    rs_a[1] = 5'd3;
    #1;
    total++;
    if (oRdDat[63:32] !== 32'hAA || oRdRdy[1] !== 1'b1) begin
      bad++; $display("FAIL fwd_priority got=%h rdy=%b exp=aa rdy=1", oRdDat[63:32], oRdRdy[1]);
    end
    tick();
    idle();
    #1;
    total++;
    if (oRdDat[63:32] !== 32'hBB || oBusy[3] !== 1'b0) begin
      bad++; $display("FAIL fwd_then_array got=%h busy=%b exp=bb busy=0", oRdDat[63:32], oBusy[3]);
    end
  endtask

  task automatic test_zero();
    idle();
    wen[0] = 1'b1; wrd[0] = '0; wdat[0] = 32'hFFFF_FFFF;
    aen = 1'b1; ard = '0;
    fvld = 1'b1; frd = '0; fdat = 32'h1234;
    rs_a[0] = '0;
    #1;
    total++;
    if (oRdDat[31:0] !== '0 || oRdRdy[0] !== 1'b1) begin
      bad++; $display("FAIL zero_bypass got=%h rdy=%b exp=0 rdy=1", oRdDat[31:0], oRdRdy[0]);
    end
    tick();
    idle();
    #1;
    total++;
    if (oBusy[0] !== 1'b0 || oRdDat[31:0] !== '0) begin
      bad++; $display("FAIL zero_state busy0=%b got=%h exp busy0=0 dat=0", oBusy[0], oRdDat[31:0]);
    end
  endtask

  task automatic test_mid_reset();
    idle();
    for (int r = 10; r < 14; r++) begin
      aen = 1'b1; ard = AWT'(r);
      wen[0] = 1'b1; wrd[0] = AWT'(r + 8); wdat[0] = 32'hC0DE_0000 + 32'(r);
      tick();
    end
    idle();
    #1;
    total++;
    if (oBusy !== m_busy_vec() || oBusy === '0) begin
      bad++; $display("FAIL pre_reset_busy got=%h exp=%h", oBusy, m_busy_vec());
    end
    rst = 1'b1;
    aen = 1'b1; ard = 5'd20;
    wen[1] = 1'b1; wrd[1] = 5'd20; wdat[1] = 32'h77;
    tick();
    rst = 1'b0;
    idle();
    #1;
    total++;
    if (oBusy !== '0) begin
      bad++; $display("FAIL mid_reset_busy got=%h exp=0", oBusy);
    end
    for (int r = 0; r < NR; r += 2) begin
      rs_a[0] = AWT'(r); rs_a[1] = AWT'(r + 1);
      #1;
      total++;
      if (oRdDat !== '0 || oRdRdy !== 2'b11) begin
        bad++; $display("FAIL mid_reset_read r=%0d got=%h rdy=%b exp=0 rdy=11", r, oRdDat, oRdRdy);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] ed;
    logic          er;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < 2; k++) begin
        wen[k]  = $urandom_range(0, 1);
        wrd[k]  = AWT'($urandom_range(0, 7));
        wdat[k] = $urandom;
        rs_a[k] = AWT'($urandom_range(0, 7));
      end
      fvld = $urandom_range(0, 2) == 0;
      frd  = AWT'($urandom_range(0, 7));
      fdat = $urandom;
      aen  = $urandom_range(0, 1);
      ard  = AWT'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < 2; p++) begin
        m_read(int'(rs_a[p]), ed, er);
        total++;
        if (oRdRdy[p] !== er || (er && oRdDat[p*DW +: DW] !== ed)) begin
          bad++; $display("FAIL rand_read c=%0d p=%0d rs=%0d got=%h rdy=%b exp=%h rdy=%b",
                          c, p, rs_a[p], oRdDat[p*DW +: DW], oRdRdy[p], ed, er);
        end
      end
      total++;
      if (oBusy !== m_busy_vec()) begin
        bad++; $display("FAIL rand_busy c=%0d got=%h exp=%h", c, oBusy, m_busy_vec());
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rs_a[0] = '0; rs_a[1] = '0;
    for (int r = 0; r < NR; r++) begin
      m_mem[r] = '0; m_busy[r] = 1'b0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_alloc_write();
    test_multi_write();
    test_alloc_write_same();
    test_fwd_priority();
    test_zero();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zion_rf_scoreboard_reg_file.md
# zion_rf_scoreboard_reg_file

Parametrised multi-write-port integer register file with an integrated busy-bit scoreboard and per-read-port forwarding. It sits between issue/decode (read and allocate) and the writeback stages (write and forward) of in-order multi-issue cores. It supersedes the single-write-port register file. Additions: configurable data width and write-port count, a same-cycle write bypass, and a per-operand ready signal so issue logic can stall without its own hazard tracking.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers (power of 2, ≥2)
- DATA_W, 32, register width in bits
- RD_PORT_NUM, 2, read (operand) ports
- WR_PORT_NUM, 2, writeback ports
- FWD_PORT_NUM, 1, forwarding sources from in-flight stages (0 allowed)
- AW, $clog2(REG_NUM), register index width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- iRdRs  in  RD_PORT_NUM×AW  source register index per read port
- oRdDat  out  RD_PORT_NUM×DATA_W  operand value per read port
- oRdRdy  out  RD_PORT_NUM  operand value valid (not hazarded)
- iWrEn  in  WR_PORT_NUM  write enable per writeback port
- iWrRd  in  WR_PORT_NUM×AW  destination index
- iWrDat  in  WR_PORT_NUM×DATA_W  write data
- iFwdVld  in  FWD_PORT_NUM  forward source holds a valid result
- iFwdRd  in  FWD_PORT_NUM×AW  forward destination index
- iFwdDat  in  FWD_PORT_NUM×DATA_W  forward data
- iAllocEn  in  1  issue of an instruction that will write iAllocRd
- iAllocRd  in  AW  destination being allocated
- oBusy  out  REG_NUM  scoreboard vector; bit r set = write to r outstanding

## Operation
- Register array: entries 1..REG_NUM-1 are flops; entry 0 reads constant 0. Writes and allocations targeting index 0 are ignored.
- Write: an entry r with any iWrEn[k] && iWrRd[k]==r loads iWrDat[k] at the next edge. If several ports target r in one cycle, the highest k wins.
- Scoreboard, per entry r≠0, evaluated per cycle:
  - alloc hit (iAllocEn && iAllocRd==r) → busy[r] set next cycle. Alloc dominates a same-cycle write clear, because the new producer is younger.
  - otherwise any write hit → busy[r] cleared.
  - otherwise busy[r] is held.
- Scoreboard, entry 0: oBusy[0] is always 0.
- Read data per port i is combinational from iRdRs[i]. The first matching source in this priority order supplies oRdDat[i]:
  1. rs==0 → 0.
  2. Forward port j with iFwdVld[j] && iFwdRd[j]==rs; the lowest j wins (youngest stage).
  3. Write port k with iWrEn[k] && iWrRd[k]==rs; the highest k wins (same-cycle bypass).
  4. Array entry rs.
- oRdRdy[i] = (rs==0) || !busy[rs] || a forward hit || a write hit.
- When oRdRdy[i]=0, oRdDat[i] carries the stale array value and must not be consumed.
- The block itself never stalls. Issue logic gates iAllocEn with the ready signals of the instruction's operands.

## Timing
- Read latency is 0 cycles (combinational). A write becomes visible through the bypass in the cycle it is presented, and from the array one cycle later.
- An allocation appears in oBusy and affects oRdRdy in the cycle after iAllocEn.
- Reset, synchronous: at the first clk edge with rst=1, all array entries become 0 and oBusy becomes 0. Writes and allocs in a reset cycle are discarded. Forwarding remains combinational during reset.
- Reset mid-operation drops all pending busy bits. The pipeline is flushed by the same rst.
- There is no combinational path from the iAlloc* inputs to any output.

## Structure
- Package zion_rf_pkg holds:
  - the AW derivation function;
  - typedefs for the register index and the data word;
  - a packed struct for one write/forward channel {vld, rd, dat}, shared by the write and forward ports.
- Sub-module zion_rf_operand_mux: one instance per read port. Inputs are rs, the array value, busy[rs], the forward channels and the write channels. Outputs are dat and rdy, using the priority above. It is purely combinational.
- The top level contains the array, the write decode and the scoreboard flops.

## Test plan
- Reset, then read all indices → oRdDat=0, oRdRdy=1, oBusy=0.
- iAllocEn with rd=5 at cycle 0 → oBusy[5]=1 and oRdRdy=0 for rs=5 at cycle 1. At cycle 3, write port 0 with rd=5, dat=0xDEADBEEF → in the same cycle oRdDat=0xDEADBEEF and oRdRdy=1. At cycle 4, busy[5]=0 and the array holds the value.
- Ports 0 and 1 both write rd=7, with 0x11 and 0x22 → the bypass and, next cycle, the array both return 0x22.
- Alloc rd=9 and write rd=9 (0x55) in the same cycle, with busy[9] previously set → the array holds 0x55 and busy[9] stays 1.
- Forward port 0 with rd=3, 0xAA, together with write port 1 with rd=3, 0xBB, and busy[3]=1 → oRdDat=0xAA and oRdRdy=1.
- Write and alloc to rd=0 → the read returns 0 and oBusy[0]=0. Assert rst with busy bits set → all state is 0 after one edge.
